// File: rtl/point_mult.sv
// Scalar multiplication Q = k*P on y^2 = x^3 - x + 1 over GF(3^97), using a
// left-to-right double-and-add loop around one sequential point adder.
`ifndef WIDTH
`define WIDTH 193
`endif

// Affine point adder. It runs one operation after every reset release. The
// micro-sequence is the same for every input pair, so its latency never depends on data.
module point_add (
    input  logic            clk,
    input  logic            reset,
    input  logic [`WIDTH:0] i_x1,
    input  logic [`WIDTH:0] i_y1,
    input  logic            i_z1,
    input  logic [`WIDTH:0] i_x2,
    input  logic [`WIDTH:0] i_y2,
    input  logic            i_z2,
    output logic [`WIDTH:0] o_x3,
    output logic [`WIDTH:0] o_y3,
    output logic            o_z3,
    output logic            o_done
);
    localparam int FW = `WIDTH + 1;
    localparam int M  = FW / 2;
    localparam logic [FW-1:0] ONE = FW'(1);

    typedef enum logic [3:0] {S_DECODE, S_SQ, S_CUBE1, S_CUBE2, S_MULA, S_LAM, S_X, S_Y, S_DONE} pa_state_t;
    typedef enum logic [1:0] {K_CALC, K_COPY1, K_COPY2, K_INF} kind_t;

    pa_state_t r_state, w_next;
    kind_t     r_kind;
    logic [FW-1:0] r_num, r_den, r_a2, r_r, r_t, r_lam, r_x3, r_y3;
    logic          r_z3, r_done;
    logic [6:0]    r_cnt;

    // Trits are 2-bit fields: 00=0, 01=1, 10=2.
    function automatic logic [1:0] t_add(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

    function automatic logic [FW-1:0] gf_add(input logic [FW-1:0] a, input logic [FW-1:0] b);
        logic [FW-1:0] r;
        r = '0;
        for (int i = 0; i < M; i++) r[2*i +: 2] = t_add(a[2*i +: 2], b[2*i +: 2]);
        return r;
    endfunction

    function automatic logic [FW-1:0] gf_sub(input logic [FW-1:0] a, input logic [FW-1:0] b);
        logic [FW-1:0] nb;
        nb = '0;
        for (int i = 0; i < M; i++) nb[2*i +: 2] = {b[2*i], b[2*i+1]};
        return gf_add(a, nb);
    endfunction

    // Horner multiply; x^97 folds back as 2x^12 + 1.
    function automatic logic [FW-1:0] gf_mul(input logic [FW-1:0] a, input logic [FW-1:0] b);
        logic [FW-1:0] r;
        logic [1:0]    c;
        r = '0;
        for (int i = M - 1; i >= 0; i--) begin
            c        = r[FW-1 -: 2];
            r        = r << 2;
            r[1:0]   = c;
            r[25:24] = t_add(r[25:24], {c[0], c[1]});
            if (b[2*i +: 2] == 2'd1)      r = gf_add(r, a);
            else if (b[2*i +: 2] == 2'd2) r = gf_sub(r, a);
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_DECODE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_DECODE: w_next = S_SQ;
            S_SQ:     w_next = S_CUBE1;
            S_CUBE1:  w_next = S_CUBE2;
            S_CUBE2:  w_next = S_MULA;
            S_MULA:   w_next = (r_cnt == 7'd1) ? S_LAM : S_CUBE1;
            S_LAM:    w_next = S_X;
            S_X:      w_next = S_Y;
            S_Y:      w_next = S_DONE;
            S_DONE:   w_next = S_DONE;
            default:  w_next = S_DECODE;
        endcase
    end

    // The inverse is den^(3^97-2): ternary digits 2,2,...,2,1 processed MSB first.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_kind <= K_CALC;
            r_num  <= '0;
            r_den  <= '0;
            r_a2   <= '0;
            r_r    <= '0;
            r_t    <= '0;
            r_lam  <= '0;
            r_cnt  <= '0;
            r_x3   <= '0;
            r_y3   <= '0;
            r_z3   <= 1'b0;
            r_done <= 1'b0;
        end else begin
            case (r_state)
                S_DECODE: begin
                    if (i_z1)              r_kind <= K_COPY2;
                    else if (i_z2)         r_kind <= K_COPY1;
                    else if (i_x1 == i_x2) r_kind <= (i_y1 == i_y2 && i_y1 != '0) ? K_CALC : K_INF;
                    else                   r_kind <= K_CALC;
                    if (i_x1 == i_x2) begin
                        r_num <= ONE;
                        r_den <= i_y1;
                    end else begin
                        r_num <= gf_sub(i_y2, i_y1);
                        r_den <= gf_sub(i_x2, i_x1);
                    end
                end
                S_SQ: begin
                    r_a2  <= gf_mul(r_den, r_den);
                    r_r   <= ONE;
                    r_cnt <= 7'd97;
                end
                S_CUBE1: r_t <= gf_mul(r_r, r_r);
                S_CUBE2: r_r <= gf_mul(r_t, r_r);
                S_MULA: begin
                    r_r   <= gf_mul(r_r, (r_cnt == 7'd1) ? r_den : r_a2);
                    r_cnt <= r_cnt - 7'd1;
                end
                S_LAM: r_lam <= gf_mul(r_num, r_r);
                S_X:   r_x3  <= gf_sub(gf_sub(gf_mul(r_lam, r_lam), i_x1), i_x2);
                S_Y: begin
                    r_done <= 1'b1;
                    case (r_kind)
                        K_COPY2: begin r_x3 <= i_x2; r_y3 <= i_y2; r_z3 <= i_z2; end
                        K_COPY1: begin r_x3 <= i_x1; r_y3 <= i_y1; r_z3 <= i_z1; end
                        K_INF:   begin r_x3 <= '0;   r_y3 <= '0;   r_z3 <= 1'b1; end
                        default: begin
                            r_y3 <= gf_sub(gf_mul(r_lam, gf_sub(i_x1, r_x3)), i_y1);
                            r_z3 <= 1'b0;
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign o_x3   = r_x3;
    assign o_y3   = r_y3;
    assign o_z3   = r_z3;
    assign o_done = r_done;
endmodule

module point_mult #(
    parameter int SCALAR_W   = 152,
    parameter int CONST_TIME = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_start,
    input  logic [SCALAR_W-1:0] i_k,
    input  logic [`WIDTH:0]     i_x,
    input  logic [`WIDTH:0]     i_y,
    input  logic                i_zero,
    output logic                o_busy,
    output logic                o_done,
    output logic [`WIDTH:0]     o_x_out,
    output logic [`WIDTH:0]     o_y_out,
    output logic                o_zero_out,
    output logic [2:0]          o_state
);
    localparam int CNT_W = $clog2(SCALAR_W + 1);

    typedef enum logic [2:0] {IDLE, DBL_GO, DBL_WAIT, ADD_GO, ADD_WAIT, NEXT, FIN} state_t;

    state_t r_state, w_next;
    logic [SCALAR_W-1:0] r_kr;
    logic [`WIDTH:0]     r_px, r_py, r_qx, r_qy, r_x_out, r_y_out;
    logic                r_pz, r_qz, r_zero_out, r_busy, r_done;
    logic [CNT_W-1:0]    r_cnt;

    logic            w_pa_go, w_pa_rst, w_sel_add, w_pa_done, w_pa_z3;
    logic [`WIDTH:0] w_pa_x3, w_pa_y3;

    // Handshake: i_start is taken only in IDLE; o_done pulses once with the result already on the outputs.
    assign w_pa_go   = (r_state == DBL_GO) || (r_state == ADD_GO);
    assign w_pa_rst  = reset | w_pa_go;
    assign w_sel_add = (r_state == ADD_GO) || (r_state == ADD_WAIT);

    point_add u_pa (
        .clk    (clk),
        .reset  (w_pa_rst),
        .i_x1   (r_qx),
        .i_y1   (r_qy),
        .i_z1   (r_qz),
        .i_x2   (w_sel_add ? r_px : r_qx),
        .i_y2   (w_sel_add ? r_py : r_qy),
        .i_z2   (w_sel_add ? r_pz : r_qz),
        .o_x3   (w_pa_x3),
        .o_y3   (w_pa_y3),
        .o_z3   (w_pa_z3),
        .o_done (w_pa_done)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (i_start) w_next = DBL_GO;
            DBL_GO:   w_next = DBL_WAIT;
            DBL_WAIT: if (w_pa_done) w_next = (r_kr[SCALAR_W-1] || (CONST_TIME != 0)) ? ADD_GO : NEXT;
            ADD_GO:   w_next = ADD_WAIT;
            ADD_WAIT: if (w_pa_done) w_next = NEXT;
            NEXT:     w_next = (r_cnt == CNT_W'(1)) ? FIN : DBL_GO;
            FIN:      w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_kr       <= '0;
            r_px       <= '0;
            r_py       <= '0;
            r_pz       <= 1'b0;
            r_qx       <= '0;
            r_qy       <= '0;
            r_qz       <= 1'b0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_x_out    <= '0;
            r_y_out    <= '0;
            r_zero_out <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (i_start) begin
                    r_kr   <= i_k;
                    r_px   <= i_x;
                    r_py   <= i_y;
                    r_pz   <= i_zero;
                    r_qx   <= '0;
                    r_qy   <= '0;
                    r_qz   <= 1'b1;
                    r_cnt  <= CNT_W'(SCALAR_W);
                    r_busy <= 1'b1;
                end
                DBL_WAIT: if (w_pa_done) begin
                    r_qx <= w_pa_x3;
                    r_qy <= w_pa_y3;
                    r_qz <= w_pa_z3;
                end
                // A dummy add on a 0 bit leaves Q untouched.
                ADD_WAIT: if (w_pa_done && r_kr[SCALAR_W-1]) begin
                    r_qx <= w_pa_x3;
                    r_qy <= w_pa_y3;
                    r_qz <= w_pa_z3;
                end
                NEXT: begin
                    r_kr  <= r_kr << 1;
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                FIN: begin
                    r_x_out    <= r_qx;
                    r_y_out    <= r_qy;
                    r_zero_out <= r_qz;
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_x_out    = r_x_out;
    assign o_y_out    = r_y_out;
    assign o_zero_out = r_zero_out;
    assign o_state    = r_state;
endmodule

// File: tb/tb_point_mult.sv
// Bench for point_mult with a 4-bit scalar: a plain instance and a constant-time instance,
// checked against hand-computed multiples of points in the GF(3) subgroup and a small GF(3) curve model.
module tb_point_mult;
    localparam int FW    = 194;
    localparam int KW    = 4;
    localparam int LIMIT = 6000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          a_start, a_zero, a_busy, a_done, a_zero_out;
    logic [KW-1:0] a_k;
    logic [FW-1:0] a_x, a_y, a_x_out, a_y_out;
    logic [2:0]    a_state;
    logic          b_start, b_zero, b_busy, b_done, b_zero_out;
    logic [KW-1:0] b_k;
    logic [FW-1:0] b_x, b_y, b_x_out, b_y_out;
    logic [2:0]    b_state;

    point_mult #(.SCALAR_W(KW), .CONST_TIME(0)) u_dut (
        .clk(clk), .reset(reset), .i_start(a_start), .i_k(a_k), .i_x(a_x), .i_y(a_y),
        .i_zero(a_zero), .o_busy(a_busy), .o_done(a_done), .o_x_out(a_x_out),
        .o_y_out(a_y_out), .o_zero_out(a_zero_out), .o_state(a_state)
    );

    point_mult #(.SCALAR_W(KW), .CONST_TIME(1)) u_dut_ct (
        .clk(clk), .reset(reset), .i_start(b_start), .i_k(b_k), .i_x(b_x), .i_y(b_y),
        .i_zero(b_zero), .o_busy(b_busy), .o_done(b_done), .o_x_out(b_x_out),
        .o_y_out(b_y_out), .o_zero_out(b_zero_out), .o_state(b_state)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    typedef struct { int x; int y; bit z; } pt_t;

    function automatic int m3(input int v);
        return ((v % 3) + 3) % 3;
    endfunction

    // Textbook affine addition over GF(3); a nonzero GF(3) element is its own inverse.
    function automatic pt_t ec_add(input pt_t p, input pt_t q);
        pt_t r;
        int  lam;
        r.x = 0; r.y = 0; r.z = 1'b1;
        if (p.z) return q;
        if (q.z) return p;
        if (p.x == q.x) begin
            if (m3(p.y + q.y) == 0) return r;
            lam = m3((3 * p.x * p.x - 1) * m3(2 * p.y));
        end else begin
            lam = m3((q.y - p.y) * m3(q.x - p.x));
        end
        r.x = m3(lam * lam - p.x - q.x);
        r.y = m3(lam * (p.x - r.x) - p.y);
        r.z = 1'b0;
        return r;
    endfunction

    function automatic pt_t mult_model(input int k, input pt_t p);
        pt_t r;
        r.x = 0; r.y = 0; r.z = 1'b1;
        for (int i = 0; i < k; i++) r = ec_add(r, p);
        return r;
    endfunction

    task automatic wait_done(input bit ct, output int cyc, output bit ok, output bit busy_ok);
        cyc = 1; ok = 1'b0; busy_ok = 1'b1;
        while (cyc < LIMIT) begin
            if (ct ? b_done : a_done) begin
                ok = 1'b1;
                break;
            end
            if (!(ct ? b_busy : a_busy)) busy_ok = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic start_mult(input bit ct, input logic [KW-1:0] k, input int px, input int py, input bit pz);
        @(posedge clk); #1;
        if (ct) begin
            b_k = k; b_x = FW'(px); b_y = FW'(py); b_zero = pz; b_start = 1'b1;
        end else begin
            a_k = k; a_x = FW'(px); a_y = FW'(py); a_zero = pz; a_start = 1'b1;
        end
        @(posedge clk); #1;
        a_start = 1'b0;
        b_start = 1'b0;
    endtask

    task automatic check_result(input string tag, input bit ct, input bit ok, input bit busy_ok,
                                input int ex, input int ey, input bit ez);
        check({tag, "_done"}, FW'(ok), FW'(1));
        check({tag, "_busy_held"}, FW'(busy_ok), FW'(1));
        check({tag, "_zero"}, FW'(ct ? b_zero_out : a_zero_out), FW'(ez));
        if (!ez) begin
            check({tag, "_x"}, ct ? b_x_out : a_x_out, FW'(ex));
            check({tag, "_y"}, ct ? b_y_out : a_y_out, FW'(ey));
        end
    endtask

    typedef struct { logic [KW-1:0] k; int px; int py; bit pz; int ex; int ey; bit ez; } vec_t;
    vec_t vecs[10];

    initial begin
        int  cyc, cyc_k0, cyc_k15, ct_c0, ct_c1, ct_c15, seen;
        bit  ok, busy_ok;
        pt_t p, m;

        // P=(0,1) has order 7: P,(1,1),(2,2),(2,1),(1,2),(0,2),O.
        vecs[0] = '{4'd0,  0, 1, 1'b0, 0, 0, 1'b1};
        vecs[1] = '{4'd1,  0, 1, 1'b0, 0, 1, 1'b0};
        vecs[2] = '{4'd2,  0, 1, 1'b0, 1, 1, 1'b0};
        vecs[3] = '{4'd3,  0, 1, 1'b0, 2, 2, 1'b0};
        vecs[4] = '{4'd15, 0, 1, 1'b0, 0, 1, 1'b0};
        vecs[5] = '{4'd5,  0, 1, 1'b1, 0, 0, 1'b1};
        vecs[6] = '{4'd7,  0, 1, 1'b0, 0, 0, 1'b1};
        vecs[7] = '{4'd4,  1, 2, 1'b0, 0, 2, 1'b0};
        vecs[8] = '{4'd9,  0, 1, 1'b0, 1, 1, 1'b0};
        vecs[9] = '{4'd6,  0, 1, 1'b0, 0, 2, 1'b0};

        reset = 1'b1;
        a_start = 1'b0; a_k = '0; a_x = '0; a_y = '0; a_zero = 1'b0;
        b_start = 1'b0; b_k = '0; b_x = '0; b_y = '0; b_zero = 1'b0;
        cyc_k0 = 0; cyc_k15 = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", FW'(a_busy), FW'(0));
        check("rst_done", FW'(a_done), FW'(0));
        check("rst_xy", a_x_out | a_y_out, FW'(0));
        check("rst_zero", FW'(a_zero_out), FW'(0));
        check("rst_state", FW'(a_state), FW'(0));
        check("rst_ct_busy", FW'(b_busy), FW'(0));
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            start_mult(1'b0, vecs[i].k, vecs[i].px, vecs[i].py, vecs[i].pz);
            wait_done(1'b0, cyc, ok, busy_ok);
            check_result($sformatf("vec%0d", i), 1'b0, ok, busy_ok, vecs[i].ex, vecs[i].ey, vecs[i].ez);
            p.x = vecs[i].px; p.y = vecs[i].py; p.z = vecs[i].pz;
            m = mult_model(int'(vecs[i].k), p);
            check($sformatf("vec%0d_model_zero", i), FW'(a_zero_out), FW'(m.z));
            if (!m.z) check($sformatf("vec%0d_model_y", i), a_y_out, FW'(m.y));
            if (vecs[i].k == 4'd0)  cyc_k0  = cyc;
            if (vecs[i].k == 4'd15) cyc_k15 = cyc;
            @(posedge clk); #1;
            check($sformatf("vec%0d_done_pulse", i), FW'(a_done), FW'(0));
        end
        check("ct0_k0_faster", FW'(cyc_k0 < cyc_k15), FW'(1));

        start_mult(1'b1, 4'd0, 0, 1, 1'b0);
        wait_done(1'b1, ct_c0, ok, busy_ok);
        check_result("ct_k0", 1'b1, ok, busy_ok, 0, 0, 1'b1);
        start_mult(1'b1, 4'd1, 0, 1, 1'b0);
        wait_done(1'b1, ct_c1, ok, busy_ok);
        check_result("ct_k1", 1'b1, ok, busy_ok, 0, 1, 1'b0);
        start_mult(1'b1, 4'd15, 0, 1, 1'b0);
        wait_done(1'b1, ct_c15, ok, busy_ok);
        check_result("ct_k15", 1'b1, ok, busy_ok, 0, 1, 1'b0);
        check("ct_cycles_k0_k1", FW'(ct_c0), FW'(ct_c1));
        check("ct_cycles_k0_k15", FW'(ct_c0), FW'(ct_c15));

        // Second start mid-run with a new k and point must be ignored.
        start_mult(1'b0, 4'd1, 0, 1, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        a_k = 4'd2; a_x = FW'(1); a_y = FW'(1); a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        wait_done(1'b0, cyc, ok, busy_ok);
        check_result("midstart", 1'b0, ok, busy_ok, 0, 1, 1'b0);

        // Reset mid-run aborts at once with no done pulse.
        start_mult(1'b0, 4'd3, 0, 1, 1'b0);
        repeat (100) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_busy", FW'(a_busy), FW'(0));
        check("abort_done", FW'(a_done), FW'(0));
        check("abort_xy", a_x_out | a_y_out, FW'(0));
        check("abort_zero", FW'(a_zero_out), FW'(0));
        check("abort_state", FW'(a_state), FW'(0));
        seen = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (a_done || a_busy) seen++;
        end
        check("abort_quiet", FW'(seen), FW'(0));
        start_mult(1'b0, 4'd2, 0, 1, 1'b0);
        wait_done(1'b0, cyc, ok, busy_ok);
        check_result("after_abort", 1'b0, ok, busy_ok, 1, 1, 1'b0);

        // Start in the same cycle as reset is dropped.
        @(posedge clk); #1;
        reset = 1'b1; a_k = 4'd3; a_start = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; a_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_start_busy", FW'(a_busy), FW'(0));
        check("rst_start_state", FW'(a_state), FW'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
